control_all_interrupt: RTL and testbench

CONTROL_ALL_INTERRUPT -- requirements
Module: controlAll_interrupt

---
 rtl/control_all_interrupt.sv | 236 +++++++++++++++++++++++
 tb/tb_control_all_interrupt.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/control_all_interrupt.sv
// control_all_interrupt
//   Main decoder for an RV64I single-cycle core with an external interrupt hook.
//   Everything is combinational from the instruction, the ALU flags and irq_in,
//   except irq_out, which is irq_in delayed by one clk.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset (clears irq_out)
//   instruction[31:0]          instruction word being decoded
//   zero, lt, ltu              ALU compare flags (equal, signed <, unsigned <)
//   irq_in                     external interrupt request
//   aluSel[4:0]                ALU operation select
//   aluSrcA / aluSrcB          operand A: rs1/PC, operand B: rs2/immediate
//   dMemWr / dMemRd            data memory write / read enables
//   PCSrc                      next PC is not PC+4
//   resultSrc[1:0]             writeback select (ALU, memory, PC+4, immediate)
//   immSrc[2:0]                immediate format (I, S, B, J, U)
//   regWr                      register-file write enable
//   jump                       JALR (target computed from rs1)
//   branch_s_o, jump_s_o       branch opcode decoded, JAL/JALR decoded
//   irq_out                    registered interrupt acknowledge
//   trap                       trap taken this cycle
module control_all_interrupt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic        zero,
  input  logic        lt,
  input  logic        ltu,
  input  logic        irq_in,
  output logic [4:0]  aluSel,
  output logic        aluSrcA,
  output logic        aluSrcB,
  output logic        dMemWr,
  output logic        dMemRd,
  output logic        PCSrc,
  output logic [1:0]  resultSrc,
  output logic [2:0]  immSrc,
  output logic        regWr,
  output logic        jump,
  output logic        branch_s_o,
  output logic        jump_s_o,
  output logic        irq_out,
  output logic        trap
);

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_SLL  = 5'b00010;
  localparam logic [4:0] ALU_SLT  = 5'b00011;
  localparam logic [4:0] ALU_SLTU = 5'b00100;
  localparam logic [4:0] ALU_XOR  = 5'b00101;
  localparam logic [4:0] ALU_SRL  = 5'b00110;
  localparam logic [4:0] ALU_SRA  = 5'b00111;
  localparam logic [4:0] ALU_OR   = 5'b01000;
  localparam logic [4:0] ALU_AND  = 5'b01001;
  localparam logic [4:0] ALU_ADDW = 5'b01010;
  localparam logic [4:0] ALU_SUBW = 5'b01011;
  localparam logic [4:0] ALU_SLLW = 5'b01100;
  localparam logic [4:0] ALU_SRLW = 5'b01101;
  localparam logic [4:0] ALU_SRAW = 5'b01110;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;
  logic       word_ok;
  logic       unused_bits;

  assign opcode      = instruction[6:0];
  assign funct3      = instruction[14:12];
  assign alt         = instruction[30];
  // Only ADD/SUB, SLL and SRL/SRA have 32-bit word forms.
  assign word_ok     = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b101);
  assign unused_bits = ^{instruction[31], instruction[29:15], instruction[11:7]};

  // allow_sub: bit 30 is an immediate bit for ADDI, so only register ops may pick SUB.
  function automatic logic [4:0] alu_int(input logic [2:0] f3, input logic a30,
                                         input logic allow_sub);
    case (f3)
      3'b000:  alu_int = (a30 && allow_sub) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_int = ALU_SLL;
      3'b010:  alu_int = ALU_SLT;
      3'b011:  alu_int = ALU_SLTU;
      3'b100:  alu_int = ALU_XOR;
      3'b101:  alu_int = a30 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_int = ALU_OR;
      default: alu_int = ALU_AND;
    endcase
  endfunction

  function automatic logic [4:0] alu_word(input logic [2:0] f3, input logic a30,
                                          input logic allow_sub);
    case (f3)
      3'b000:  alu_word = (a30 && allow_sub) ? ALU_SUBW : ALU_ADDW;
      3'b001:  alu_word = ALU_SLLW;
      3'b101:  alu_word = a30 ? ALU_SRAW : ALU_SRLW;
      default: alu_word = ALU_ADD;
    endcase
  endfunction

  logic [4:0] alu_sel;
  logic       src_a, src_b, mem_wr, mem_rd, reg_wr, jmp, br, js, cond;
  logic [1:0] res_src;
  logic [2:0] imm_src;

  always_comb begin
    alu_sel = ALU_ADD;
    src_a   = 1'b0;
    src_b   = 1'b0;
    mem_wr  = 1'b0;
    mem_rd  = 1'b0;
    reg_wr  = 1'b0;
    jmp     = 1'b0;
    br      = 1'b0;
    js      = 1'b0;
    cond    = 1'b0;
    res_src = 2'b00;
    imm_src = IMM_I;
    case (opcode)
      OPC_LOAD: if (funct3 != 3'b111) begin
        reg_wr  = 1'b1;
        src_b   = 1'b1;
        mem_rd  = 1'b1;
        res_src = 2'b01;
      end
      OPC_OPIMM: begin
        reg_wr  = 1'b1;
        src_b   = 1'b1;
        alu_sel = alu_int(funct3, alt, 1'b0);
      end
      OPC_OPIMM32: if (word_ok) begin
        reg_wr  = 1'b1;
        src_b   = 1'b1;
        alu_sel = alu_word(funct3, alt, 1'b0);
      end
      OPC_OP: begin
        reg_wr  = 1'b1;
        alu_sel = alu_int(funct3, alt, 1'b1);
      end
      OPC_OP32: if (word_ok) begin
        reg_wr  = 1'b1;
        alu_sel = alu_word(funct3, alt, 1'b1);
      end
      OPC_STORE: if (!funct3[2]) begin
        mem_wr  = 1'b1;
        src_b   = 1'b1;
        imm_src = IMM_S;
      end
      OPC_BRANCH: begin
        br      = 1'b1;
        alu_sel = ALU_SUB;
        imm_src = IMM_B;
        case (funct3)
          3'b000:  cond = zero;
          3'b001:  cond = !zero;
          3'b100:  cond = lt;
          3'b101:  cond = !lt;
          3'b110:  cond = ltu;
          3'b111:  cond = !ltu;
          default: cond = 1'b0;
        endcase
      end
      OPC_JAL: begin
        js      = 1'b1;
        reg_wr  = 1'b1;
        res_src = 2'b10;
        imm_src = IMM_J;
        src_a   = 1'b1;
        src_b   = 1'b1;
      end
      OPC_JALR: begin
        js      = 1'b1;
        jmp     = 1'b1;
        reg_wr  = 1'b1;
        res_src = 2'b10;
        src_b   = 1'b1;
      end
      OPC_LUI: begin
        reg_wr  = 1'b1;
        res_src = 2'b11;
        imm_src = IMM_U;
      end
      OPC_AUIPC: begin
        reg_wr  = 1'b1;
        src_a   = 1'b1;
        src_b   = 1'b1;
        imm_src = IMM_U;
      end
      default: ;
    endcase
  end

  // An interrupt suppresses all architectural side effects and redirects the PC.
  assign aluSel     = alu_sel;
  assign aluSrcA    = src_a;
  assign aluSrcB    = src_b;
  assign resultSrc  = res_src;
  assign immSrc     = imm_src;
  assign jump       = jmp;
  assign branch_s_o = br;
  assign jump_s_o   = js;
  assign regWr      = reg_wr & ~irq_in;
  assign dMemWr     = mem_wr & ~irq_in;
  assign dMemRd     = mem_rd & ~irq_in;
  assign PCSrc      = (br & cond) | js | irq_in;
  assign trap       = irq_in;

  logic irq_q, irq_d;

  assign irq_d = irq_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign irq_out = irq_q;

endmodule

// File: tb/tb_control_all_interrupt.sv
module tb_control_all_interrupt;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction;
  logic        zero, lt, ltu, irq_in;
  logic [4:0]  aluSel;
  logic        aluSrcA, aluSrcB, dMemWr, dMemRd, PCSrc;
  logic [1:0]  resultSrc;
  logic [2:0]  immSrc;
  logic        regWr, jump, branch_s_o, jump_s_o, irq_out, trap;

  int checks = 0;
  int errors = 0;
  logic exp_irq;

  control_all_interrupt dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction),
    .zero(zero), .lt(lt), .ltu(ltu), .irq_in(irq_in),
    .aluSel(aluSel), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .dMemWr(dMemWr), .dMemRd(dMemRd), .PCSrc(PCSrc),
    .resultSrc(resultSrc), .immSrc(immSrc), .regWr(regWr),
    .jump(jump), .branch_s_o(branch_s_o), .jump_s_o(jump_s_o),
    .irq_out(irq_out), .trap(trap)
  );

  always #5 clk = ~clk;

  // Packed view: {aluSel, srcA, srcB, memWr, memRd, PCSrc, resultSrc, immSrc, regWr, jump, branch, jumps, trap}
  logic [19:0] dut_vec;
  assign dut_vec = {aluSel, aluSrcA, aluSrcB, dMemWr, dMemRd, PCSrc, resultSrc, immSrc,
                    regWr, jump, branch_s_o, jump_s_o, trap};

  // Reference decoder built from the instruction-set tables.
  function automatic logic [19:0] model(input logic [31:0] ins, input logic z, input logic l,
                                        input logic lu, input logic irq);
    int base_tab[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int alu = 0, res = 0, imm = 0, f3;
    bit a = 0, b = 0, mw = 0, mr = 0, rw = 0, j = 0, br = 0, js = 0, cond = 0, pc;
    bit alt;
    logic [6:0] op;
    op  = ins[6:0];
    f3  = int'(ins[14:12]);
    alt = ins[30];
    if (op == 7'b0000011 && f3 != 7) begin
      rw = 1; b = 1; mr = 1; res = 1;
    end else if (op == 7'b0010011 || op == 7'b0110011) begin
      rw  = 1;
      b   = (op == 7'b0010011);
      alu = base_tab[f3];
      if (f3 == 5 && alt) alu = alu + 1;
      if (f3 == 0 && alt && op == 7'b0110011) alu = 1;
    end else if ((op == 7'b0011011 || op == 7'b0111011) && (f3 == 0 || f3 == 1 || f3 == 5)) begin
      rw = 1;
      b  = (op == 7'b0011011);
      if (f3 == 0)      alu = (alt && op == 7'b0111011) ? 11 : 10;
      else if (f3 == 1) alu = 12;
      else              alu = alt ? 14 : 13;
    end else if (op == 7'b0100011 && f3 < 4) begin
      mw = 1; b = 1; imm = 1;
    end else if (op == 7'b1100011) begin
      br = 1; alu = 1; imm = 2;
      if (f3 == 0) cond = z;
      if (f3 == 1) cond = !z;
      if (f3 == 4) cond = l;
      if (f3 == 5) cond = !l;
      if (f3 == 6) cond = lu;
      if (f3 == 7) cond = !lu;
    end else if (op == 7'b1101111) begin
      js = 1; rw = 1; res = 2; imm = 3; a = 1; b = 1;
    end else if (op == 7'b1100111) begin
      js = 1; j = 1; rw = 1; res = 2; b = 1;
    end else if (op == 7'b0110111) begin
      rw = 1; res = 3; imm = 4;
    end else if (op == 7'b0010111) begin
      rw = 1; a = 1; b = 1; imm = 4;
    end
    pc = (br && cond) || js || irq;
    if (irq) begin
      rw = 0; mw = 0; mr = 0;
    end
    model = {alu[4:0], a, b, mw, mr, pc, res[1:0], imm[2:0], rw, j, br, js, irq};
  endfunction

  task automatic check(input logic [19:0] act, input logic [19:0] exp, input string nm);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ins=%h actual=%b required=%b", nm, instruction, act, exp);
    end
  endtask

  // Reference for the interrupt acknowledge flop.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_irq <= 1'b0;
    else        exp_irq <= irq_in;
  end

  always @(negedge clk) begin
    check(dut_vec, model(instruction, zero, lt, ltu, irq_in), "comb_vs_model");
    check({19'd0, irq_out}, {19'd0, exp_irq}, "irq_out_vs_model");
  end

  // Drive one vector just after a rising edge, then at the falling edge compare
  // both the DUT and the reference model against a hand-computed literal.
  task automatic vec(input logic [31:0] ins, input logic z, input logic l, input logic lu,
                     input logic irq, input logic [19:0] exp, input string nm);
    @(posedge clk);
    #1;
    instruction = ins; zero = z; lt = l; ltu = lu; irq_in = irq;
    @(negedge clk);
    check(dut_vec, exp, nm);
    check(model(ins, z, l, lu, irq), exp, {nm, "_model"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] ops[12];
    logic [31:0] ins;
    ops = '{7'b0000011, 7'b0010011, 7'b0011011, 7'b0110011, 7'b0111011, 7'b0100011,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
    rst_n = 1'b0; instruction = 32'h0000B103; zero = 0; lt = 0; ltu = 0; irq_in = 1'b1;
    #2;
    check({19'd0, irq_out}, 20'd0, "reset_irq_out");
    check(dut_vec, 20'b00000_0_1_0_0_1_01_000_0_0_0_0_1, "comb_in_reset");
    #10 rst_n = 1'b1;

    vec(32'h0000B103, 0, 0, 0, 0, 20'b00000_0_1_0_1_0_01_000_1_0_0_0_0, "ld");
    vec(32'h4010D11B, 0, 0, 0, 0, 20'b01110_0_1_0_0_0_00_000_1_0_0_0_0, "sraiw");
    vec(32'h402081B3, 0, 0, 0, 0, 20'b00001_0_0_0_0_0_00_000_1_0_0_0_0, "sub");
    vec(32'h00208063, 1, 0, 0, 0, 20'b00001_0_0_0_0_1_00_010_0_0_1_0_0, "beq_taken");
    vec(32'h00208063, 0, 0, 0, 0, 20'b00001_0_0_0_0_0_00_010_0_0_1_0_0, "beq_not_taken");
    vec(32'h0020D063, 0, 1, 0, 0, 20'b00001_0_0_0_0_0_00_010_0_0_1_0_0, "bge_lt");
    vec(32'h0020F063, 0, 0, 0, 0, 20'b00001_0_0_0_0_1_00_010_0_0_1_0_0, "bgeu_ge");
    vec(32'h0020A063, 1, 1, 1, 0, 20'b00001_0_0_0_0_0_00_010_0_0_1_0_0, "branch_f3_010");
    vec(32'h00108167, 0, 0, 0, 0, 20'b00000_0_1_0_0_1_10_000_1_1_0_1_0, "jalr");
    vec(32'h0000006F, 0, 0, 0, 0, 20'b00000_1_1_0_0_1_10_011_1_0_0_1_0, "jal");
    vec(32'h000010B7, 0, 0, 0, 0, 20'b00000_0_0_0_0_0_11_100_1_0_0_0_0, "lui");
    vec(32'h00001097, 0, 0, 0, 0, 20'b00000_1_1_0_0_0_00_100_1_0_0_0_0, "auipc");
    vec(32'h0020B023, 0, 0, 0, 0, 20'b00000_0_1_1_0_0_00_001_0_0_0_0_0, "sd");
    vec(32'h0000007F, 0, 0, 0, 0, 20'b00000_0_0_0_0_0_00_000_0_0_0_0_0, "unlisted");
    vec(32'h0000007F, 0, 0, 0, 1, 20'b00000_0_0_0_0_1_00_000_0_0_0_0_1, "unlisted_irq");
    vec(32'h0020B023, 0, 0, 0, 1, 20'b00000_0_1_0_0_1_00_001_0_0_0_0_1, "sd_trap");
    vec(32'h002081B3, 0, 0, 0, 1, 20'b00000_0_0_0_0_1_00_000_0_0_0_0_1, "add_trap");

    // irq_out follows irq_in one edge later
    @(posedge clk); #1;
    check({19'd0, irq_out}, 20'd1, "irq_out_set");
    irq_in = 1'b0;
    @(posedge clk); #1;
    check({19'd0, irq_out}, 20'd0, "irq_out_clear");

    // async clear between edges
    irq_in = 1'b1;
    @(posedge clk); #1;
    check({19'd0, irq_out}, 20'd1, "irq_out_before_rst");
    #2 rst_n = 1'b0;
    #1 check({19'd0, irq_out}, 20'd0, "irq_out_async_rst");
    rst_n = 1'b1;
    irq_in = 1'b0;

    // sweep every opcode, funct3 and bit-30 with varied flags; model checks each cycle
    foreach (ops[k]) begin
      for (int f = 0; f < 8; f++) begin
        for (int s = 0; s < 2; s++) begin
          @(posedge clk); #1;
          ins = $urandom;
          ins[6:0] = ops[k];
          ins[14:12] = f[2:0];
          ins[30] = s[0];
          instruction = ins;
          zero = 1'($urandom_range(0, 1));
          lt   = 1'($urandom_range(0, 1));
          ltu  = 1'($urandom_range(0, 1));
          irq_in = ($urandom_range(0, 3) == 0);
        end
      end
    end
    @(negedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
